// File: rtl/elevator_pkg.sv
// Shared constants for the elevator scan controller: state encodings, default sizing, request flags.
// Optional feature macro: ELEVATOR_EMERGENCY_RECALL_EN (see elevator_scan_controller.sv).
package elevator_pkg;

  localparam int DEF_NUM_FLOORS    = 11;
  localparam int DEF_FLOOR_W       = 4;
  localparam int DEF_TRAVEL_CYCLES = 4;
  localparam int DEF_DOOR_CYCLES   = 8;

  // Encodings are visible on the state output, so they must stay stable.
  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_MOVING    = 3'd2;
  localparam logic [2:0] ST_DOOR_OPEN = 3'd3;
  localparam logic [2:0] ST_EMERGENCY = 3'd4;

  typedef struct packed {
    logic any_above;   // a pending request strictly above current_floor
    logic any_below;   // a pending request strictly below current_floor
    logic at_floor;    // a pending request at current_floor
    logic hit_next;    // a pending request at the floor about to be reached
    logic press_here;  // a button for current_floor is being pressed right now
  } req_flags_t;

endpackage

// File: rtl/elevator_request_bank.sv
// Hall/cab request storage with set/clear arbitration and position-relative summary flags.
// Optional feature macro: ELEVATOR_EMERGENCY_RECALL_EN (not used in this file).
module elevator_request_bank
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_buttons,
  input  logic [NUM_FLOORS-1:0] panel_buttons,
  input  logic                  accept,
  input  logic                  suppress_here,
  input  logic                  clear_all,
  input  logic                  clear_floor_en,
  input  logic [FLOOR_W-1:0]    clear_floor,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic [FLOOR_W-1:0]    next_floor,
  output logic [NUM_FLOORS-1:0] call_req,
  output logic [NUM_FLOORS-1:0] panel_req,
  output req_flags_t            flags
);

  logic [NUM_FLOORS-1:0] here_mask, next_mask, above_mask, below_mask, clr_mask, set_mask;
  logic [NUM_FLOORS-1:0] pending;

  // NOTE: every mask gets a default before the loop so this block can never infer a latch.
  always_comb begin
    here_mask  = '0;
    next_mask  = '0;
    above_mask = '0;
    below_mask = '0;
    clr_mask   = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      here_mask[i]  = (FLOOR_W'(i) == current_floor);
      next_mask[i]  = (FLOOR_W'(i) == next_floor);
      above_mask[i] = (FLOOR_W'(i) >  current_floor);
      below_mask[i] = (FLOOR_W'(i) <  current_floor);
      clr_mask[i]   = clear_all | (clear_floor_en && (FLOOR_W'(i) == clear_floor));
    end
    set_mask = accept ? ~({NUM_FLOORS{suppress_here}} & here_mask) : '0;
  end

  // NOTE: non-blocking assignments so both banks update from pre-edge values; clear is applied last and wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      call_req  <= '0;
      panel_req <= '0;
    end else begin
      call_req  <= (call_req  | (call_buttons  & set_mask)) & ~clr_mask;
      panel_req <= (panel_req | (panel_buttons & set_mask)) & ~clr_mask;
    end
  end

  assign pending          = call_req | panel_req;
  assign flags.any_above  = |(pending & above_mask);
  assign flags.any_below  = |(pending & below_mask);
  assign flags.at_floor   = |(pending & here_mask);
  assign flags.hit_next   = |(pending & next_mask);
  assign flags.press_here = |((call_buttons | panel_buttons) & here_mask);

endmodule

// File: rtl/elevator_scan_controller.sv
// SCAN elevator controller: serves requests in the current direction, reverses only when idle.
// Macro ELEVATOR_EMERGENCY_RECALL_EN: emergency recalls the cab to floor 0; otherwise emergency freezes it.
module elevator_scan_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int FLOOR_W       = DEF_FLOOR_W,
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_buttons,
  input  logic [NUM_FLOORS-1:0] panel_buttons,
  input  logic                  door_open_btn,
  input  logic                  door_close_btn,
  input  logic                  emergency_btn,
  input  logic                  power_switch,
  input  logic                  weight_sensor,
  output logic [NUM_FLOORS-1:0] call_lights,
  output logic [NUM_FLOORS-1:0] panel_lights,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  direction_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [2:0]            state
);

  localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DCW = $clog2(DOOR_CYCLES);
  localparam logic [TCW-1:0]     TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
  localparam logic [DCW-1:0]     DOOR_LAST   = DCW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  logic [2:0]         state_d;
  logic [FLOOR_W-1:0] floor_d, next_floor, clear_floor;
  logic [TCW-1:0]     travel_cnt, travel_d;
  logic [DCW-1:0]     door_cnt, door_d;
  logic               dir_q, dir_d;
  logic               accept, suppress_here, clear_all, clear_floor_en;
  req_flags_t         flags;

  elevator_request_bank #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_requests (
    .clock          (clock),
    .reset          (reset),
    .call_buttons   (call_buttons),
    .panel_buttons  (panel_buttons),
    .accept         (accept),
    .suppress_here  (suppress_here),
    .clear_all      (clear_all),
    .clear_floor_en (clear_floor_en),
    .clear_floor    (clear_floor),
    .current_floor  (current_floor),
    .next_floor     (next_floor),
    .call_req       (call_lights),
    .panel_req      (panel_lights),
    .flags          (flags)
  );

  assign next_floor = dir_q ? current_floor + 1'b1 : current_floor - 1'b1;

  always_comb begin
    state_d        = state;
    floor_d        = current_floor;
    dir_d          = dir_q;
    travel_d       = travel_cnt;
    door_d         = door_cnt;
    accept         = 1'b1;
    suppress_here  = (state == ST_IDLE) || (state == ST_DOOR_OPEN);
    clear_all      = 1'b0;
    clear_floor_en = 1'b0;
    clear_floor    = current_floor;

    if (!power_switch) begin
      state_d   = ST_OFF;
      travel_d  = '0;
      door_d    = '0;
      accept    = 1'b0;
      clear_all = 1'b1;
    end else if (emergency_btn) begin
      state_d = ST_EMERGENCY;
`ifdef ELEVATOR_EMERGENCY_RECALL_EN
      accept    = 1'b0;
      clear_all = 1'b1;
      if (state != ST_EMERGENCY) begin
        travel_d = '0;
      end else if (current_floor != '0) begin
        if (travel_cnt == TRAVEL_LAST) begin
          floor_d  = current_floor - 1'b1;
          travel_d = '0;
        end else begin
          travel_d = travel_cnt + 1'b1;
        end
      end
`endif
    end else begin
      case (state)
        ST_OFF: begin
          // Any partial travel before the outage is forgotten.
          state_d  = ST_IDLE;
          travel_d = '0;
          door_d   = '0;
        end
        ST_EMERGENCY: state_d = ST_IDLE;
        ST_IDLE: begin
          if (door_open_btn || flags.press_here || flags.at_floor) begin
            state_d        = ST_DOOR_OPEN;
            door_d         = DOOR_LAST;
            clear_floor_en = flags.at_floor;
          end else if (flags.any_above && (!flags.any_below || dir_q)) begin
            state_d  = ST_MOVING;
            dir_d    = 1'b1;
            travel_d = '0;
          end else if (flags.any_below) begin
            state_d  = ST_MOVING;
            dir_d    = 1'b0;
            travel_d = '0;
          end
        end
        ST_MOVING: begin
          if (travel_cnt != TRAVEL_LAST) begin
            travel_d = travel_cnt + 1'b1;
          end else if ((dir_q && current_floor == TOP_FLOOR) || (!dir_q && current_floor == '0)) begin
            state_d  = ST_IDLE;
            travel_d = '0;
          end else begin
            floor_d  = next_floor;
            travel_d = '0;
            if (flags.hit_next) begin
              state_d        = ST_DOOR_OPEN;
              door_d         = DOOR_LAST;
              clear_floor_en = 1'b1;
              clear_floor    = next_floor;
            end else if (!(dir_q ? flags.any_above : flags.any_below)) begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DOOR_OPEN: begin
          if (door_open_btn || weight_sensor) begin
            door_d = DOOR_LAST;
          end else if (door_close_btn) begin
            state_d = ST_IDLE;
            door_d  = '0;
          end else if (flags.press_here) begin
            door_d = DOOR_LAST;
          end else if (door_cnt == '0) begin
            state_d = ST_IDLE;
          end else begin
            door_d = door_cnt - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      current_floor <= '0;
      dir_q         <= 1'b1;
      travel_cnt    <= '0;
      door_cnt      <= '0;
    end else begin
      state         <= state_d;
      current_floor <= floor_d;
      dir_q         <= dir_d;
      travel_cnt    <= travel_d;
      door_cnt      <= door_d;
    end
  end

  assign direction_up = dir_q && (state != ST_OFF);
`ifdef ELEVATOR_EMERGENCY_RECALL_EN
  assign moving    = (state == ST_MOVING) || ((state == ST_EMERGENCY) && (current_floor != '0));
  assign door_open = (state == ST_DOOR_OPEN) || ((state == ST_EMERGENCY) && (current_floor == '0));
`else
  assign moving    = (state == ST_MOVING);
  assign door_open = (state == ST_DOOR_OPEN);
`endif

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Directed self-checking bench for elevator_scan_controller at default parameters.
// Emergency expectations follow ELEVATOR_EMERGENCY_RECALL_EN when it is defined for the build.
module tb_elevator_scan_controller;
  import elevator_pkg::*;

  localparam int NF = 11;

  logic          clock = 1'b0;
  logic          reset;
  logic [NF-1:0] call_buttons, panel_buttons;
  logic          door_open_btn, door_close_btn, emergency_btn, power_switch, weight_sensor;
  logic [NF-1:0] call_lights, panel_lights;
  logic [3:0]    current_floor;
  logic          direction_up, moving, door_open;
  logic [2:0]    state;

  int checks   = 0;
  int failures = 0;

  elevator_scan_controller dut (
    .clock          (clock),
    .reset          (reset),
    .call_buttons   (call_buttons),
    .panel_buttons  (panel_buttons),
    .door_open_btn  (door_open_btn),
    .door_close_btn (door_close_btn),
    .emergency_btn  (emergency_btn),
    .power_switch   (power_switch),
    .weight_sensor  (weight_sensor),
    .call_lights    (call_lights),
    .panel_lights   (panel_lights),
    .current_floor  (current_floor),
    .direction_up   (direction_up),
    .moving         (moving),
    .door_open      (door_open),
    .state          (state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_until_state(input logic [2:0] st, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (state === st) begin n = i; break; end
    end
  endtask

  task automatic run_until_floor(input logic [3:0] fl, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (current_floor === fl) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; power_switch = 1'b1;
    call_buttons = '0; panel_buttons = '0;
    door_open_btn = 0; door_close_btn = 0; emergency_btn = 0; weight_sensor = 0;
    repeat (3) @(negedge clock);
    checks++;
    if ({state, current_floor, direction_up, moving, door_open} !== {ST_IDLE, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: state=%0d floor=%0d up=%b mv=%b door=%b, required 1 0 1 0 0",
               state, current_floor, direction_up, moving, door_open);
    end
    checks++;
    if ({call_lights, panel_lights} !== '0) begin
      failures++; $display("FAIL reset_lights: call=%b panel=%b, required all 0", call_lights, panel_lights);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_call();
    int n, dn;
    panel_buttons = NF'(1) << 5; tick(); panel_buttons = '0;
    checks++;
    if (panel_lights !== NF'(1) << 5) begin
      failures++; $display("FAIL latch_panel5: lights=%b, required bit 5 only", panel_lights);
    end
    run_until_state(ST_MOVING, 5, n);
    checks++;
    if (n !== 1 || moving !== 1'b1) begin
      failures++; $display("FAIL start_moving: cycles=%0d moving=%b, required 1 and 1", n, moving);
    end
    run_until_floor(4'd5, 100, n);
    checks++;
    if (n !== 20) begin
      failures++; $display("FAIL travel_time_5: cycles=%0d, required 20", n);
    end
    checks++;
    if (state !== ST_DOOR_OPEN || door_open !== 1'b1 || panel_lights !== '0) begin
      failures++;
      $display("FAIL arrive_5: state=%0d door=%b lights=%b, required 3 1 0", state, door_open, panel_lights);
    end
    dn = 0;
    while (door_open === 1'b1 && dn < 50) begin dn++; tick(); end
    checks++;
    if (dn !== 8 || state !== ST_IDLE) begin
      failures++; $display("FAIL door_time: open_cycles=%0d state=%0d, required 8 and 1", dn, state);
    end
  endtask

  task automatic test_scan();
    int n;
    panel_buttons = NF'(1) << 9; tick(); panel_buttons = '0;
    run_until_state(ST_MOVING, 5, n);
    call_buttons = (NF'(1) << 2) | (NF'(1) << 7); tick(); call_buttons = '0;
    checks++;
    if (call_lights !== ((NF'(1) << 2) | (NF'(1) << 7)) || panel_lights !== NF'(1) << 9) begin
      failures++; $display("FAIL scan_latch: call=%b panel=%b, required bits 2,7 and 9", call_lights, panel_lights);
    end
    run_until_state(ST_DOOR_OPEN, 100, n);
    checks++;
    if (n < 0 || current_floor !== 4'd7 || call_lights !== NF'(1) << 2) begin
      failures++; $display("FAIL scan_stop7: floor=%0d call=%b, required 7 and bit 2", current_floor, call_lights);
    end
    run_until_state(ST_IDLE, 50, n);
    run_until_state(ST_DOOR_OPEN, 100, n);
    checks++;
    if (n < 0 || current_floor !== 4'd9 || direction_up !== 1'b1 || panel_lights !== '0) begin
      failures++;
      $display("FAIL scan_stop9: floor=%0d up=%b panel=%b, required 9 1 0", current_floor, direction_up, panel_lights);
    end
    run_until_state(ST_IDLE, 50, n);
    run_until_state(ST_DOOR_OPEN, 100, n);
    checks++;
    if (n < 0 || current_floor !== 4'd2 || direction_up !== 1'b0 || call_lights !== '0) begin
      failures++;
      $display("FAIL scan_stop2: floor=%0d up=%b call=%b, required 2 0 0", current_floor, direction_up, call_lights);
    end
  endtask

  task automatic test_door_hold();
    int bad = 0;
    weight_sensor = 1'b1; door_close_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (door_open !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL weight_hold: closed_cycles=%0d, required 0", bad);
    end
    weight_sensor = 1'b0; tick(); door_close_btn = 1'b0;
    checks++;
    if (state !== ST_IDLE || door_open !== 1'b0) begin
      failures++; $display("FAIL close_btn: state=%0d door=%b, required 1 0", state, door_open);
    end
  endtask

  task automatic test_door_at_floor();
    int dn;
    call_buttons = NF'(1) << 2; tick(); call_buttons = '0;
    checks++;
    if (door_open !== 1'b1 || call_lights !== '0) begin
      failures++; $display("FAIL here_opens: door=%b call=%b, required 1 0", door_open, call_lights);
    end
    repeat (5) tick();
    panel_buttons = NF'(1) << 2; tick(); panel_buttons = '0;
    dn = 0;
    while (door_open === 1'b1 && dn < 50) begin dn++; tick(); end
    checks++;
    if (dn !== 8 || panel_lights !== '0) begin
      failures++; $display("FAIL here_restart: open_cycles=%0d panel=%b, required 8 0", dn, panel_lights);
    end
  endtask

  task automatic test_power_off();
    int n, bad;
    panel_buttons = NF'(1) << 8; tick(); panel_buttons = '0;
    run_until_floor(4'd3, 50, n);
    tick(); tick();
    power_switch = 1'b0; tick();
    checks++;
    if ({state, moving, door_open, direction_up} !== 6'd0 || current_floor !== 4'd3 || panel_lights !== '0) begin
      failures++;
      $display("FAIL power_off: state=%0d mv=%b door=%b up=%b floor=%0d panel=%b, required 0 0 0 0 3 0",
               state, moving, door_open, direction_up, current_floor, panel_lights);
    end
    panel_buttons = NF'(1) << 6; tick(); panel_buttons = '0;
    checks++;
    if (panel_lights !== '0 || state !== ST_OFF) begin
      failures++; $display("FAIL off_ignores: panel=%b state=%0d, required 0 0", panel_lights, state);
    end
    power_switch = 1'b1; tick();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (moving !== 1'b0 || state !== ST_IDLE) bad++;
      tick();
    end
    checks++;
    if (bad !== 0 || current_floor !== 4'd3) begin
      failures++; $display("FAIL power_restore: bad_cycles=%0d floor=%0d, required 0 3", bad, current_floor);
    end
  endtask

  task automatic test_emergency();
    int n;
    panel_buttons = NF'(1) << 6; tick(); panel_buttons = '0;
    run_until_state(ST_DOOR_OPEN, 60, n);
    checks++;
    if (n < 0 || current_floor !== 4'd6) begin
      failures++; $display("FAIL reach6: floor=%0d, required 6", current_floor);
    end
    door_close_btn = 1'b1; tick(); door_close_btn = 1'b0;
    panel_buttons = (NF'(1) << 8) | (NF'(1) << 9); emergency_btn = 1'b1; tick(); panel_buttons = '0;
    checks++;
    if (state !== ST_EMERGENCY) begin
      failures++; $display("FAIL emerg_enter: state=%0d, required 4", state);
    end
`ifdef ELEVATOR_EMERGENCY_RECALL_EN
    run_until_floor(4'd0, 100, n);
    checks++;
    if (n !== 24 || panel_lights !== '0 || door_open !== 1'b1 || moving !== 1'b0) begin
      failures++;
      $display("FAIL recall: cycles=%0d panel=%b door=%b mv=%b, required 24 0 1 0", n, panel_lights, door_open, moving);
    end
    emergency_btn = 1'b0; tick();
    checks++;
    if (state !== ST_IDLE || door_open !== 1'b0) begin
      failures++; $display("FAIL emerg_exit: state=%0d door=%b, required 1 0", state, door_open);
    end
`else
    repeat (10) tick();
    checks++;
    if (current_floor !== 4'd6 || moving !== 1'b0 || door_open !== 1'b0 ||
        panel_lights !== ((NF'(1) << 8) | (NF'(1) << 9))) begin
      failures++;
      $display("FAIL freeze: floor=%0d mv=%b door=%b panel=%b, required 6 0 0 bits 8,9",
               current_floor, moving, door_open, panel_lights);
    end
    emergency_btn = 1'b0; tick();
    run_until_state(ST_DOOR_OPEN, 60, n);
    checks++;
    if (n < 0 || current_floor !== 4'd8 || panel_lights !== NF'(1) << 9) begin
      failures++; $display("FAIL resume8: floor=%0d panel=%b, required 8 bit 9", current_floor, panel_lights);
    end
    run_until_state(ST_IDLE, 50, n);
    run_until_state(ST_DOOR_OPEN, 60, n);
    run_until_state(ST_IDLE, 50, n);
    checks++;
    if (n < 0 || current_floor !== 4'd9) begin
      failures++; $display("FAIL resume9: floor=%0d, required 9", current_floor);
    end
`endif
  endtask

  task automatic test_reset_mid_move();
    int n, bad;
    logic [3:0] exp_floor;
`ifdef ELEVATOR_EMERGENCY_RECALL_EN
    exp_floor = 4'd1;
`else
    exp_floor = 4'd8;
`endif
    panel_buttons = NF'(1) << 4; tick(); panel_buttons = '0;
    run_until_state(ST_MOVING, 5, n);
    repeat (6) tick();
    checks++;
    if (current_floor !== exp_floor || moving !== 1'b1) begin
      failures++; $display("FAIL pre_reset_move: floor=%0d mv=%b, required %0d 1", current_floor, moving, exp_floor);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({state, current_floor, direction_up, moving, door_open} !== {ST_IDLE, 4'd0, 1'b1, 1'b0, 1'b0} ||
        {call_lights, panel_lights} !== '0) begin
      failures++;
      $display("FAIL async_reset: state=%0d floor=%0d up=%b mv=%b door=%b panel=%b, required 1 0 1 0 0 0",
               state, current_floor, direction_up, moving, door_open, panel_lights);
    end
    @(negedge clock); reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (moving !== 1'b0 || current_floor !== 4'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL post_reset_still: bad_cycles=%0d, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_scan();
    test_door_hold();
    test_door_at_floor();
    test_power_off();
    test_emergency();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevator_scan_controller.md
ELEVATOR_SCAN_CONTROLLER -- requirements
Module: elevator_scan_controller

Interface
REQ-001 Parameter NUM_FLOORS, default 11, number of served floors (2..16).
REQ-002 Parameter FLOOR_W, default 4, width of floor index; SHALL satisfy 2**FLOOR_W >= NUM_FLOORS.
REQ-003 Parameter TRAVEL_CYCLES, default 4, clock cycles per one-floor move (>=1).
REQ-004 Parameter DOOR_CYCLES, default 8, clock cycles door stays open (>=2).
REQ-005 clock  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 call_buttons  input  NUM_FLOORS  debounced hall call, one bit per floor, level-high.
REQ-008 panel_buttons  input  NUM_FLOORS  debounced cab destination, one bit per floor.
REQ-009 door_open_btn, door_close_btn, emergency_btn  input  1 each  debounced cab controls.
REQ-010 power_switch  input  1  1 = powered; weight_sensor  input  1  1 = overweight.
REQ-011 call_lights, panel_lights  output  NUM_FLOORS  pending-request illumination.
REQ-012 current_floor  output  FLOOR_W  cab position; direction_up  output  1; moving  output  1; door_open  output  1.
REQ-013 state  output  3  current FSM state encoding, for display.

Function
REQ-014 A 1 on call_buttons[k]/panel_buttons[k] SHALL set the matching request bit at the next edge; lights equal request bits.
REQ-015 Request at current_floor while in IDLE or DOOR_OPEN SHALL not latch; it SHALL open/restart the door instead.
REQ-016 States: OFF, IDLE, MOVING, DOOR_OPEN, EMERGENCY; encoding fixed in the shared package.
REQ-017 IDLE: requests above only -> MOVING up; below only -> MOVING down; both -> keep direction_up; none -> stay IDLE.
REQ-018 MOVING: moving=1; travel counter cleared on entry; current_floor steps +/-1 exactly TRAVEL_CYCLES cycles after MOVING entry or previous step.
REQ-019 On step to floor k with either request bit k set: -> DOOR_OPEN, clear both bits k the same edge; else continue if requests remain ahead, else IDLE.
REQ-020 current_floor SHALL never go below 0 or above NUM_FLOORS-1; direction reverses only in IDLE/DOOR_OPEN.
REQ-021 DOOR_OPEN: door_open=1 for DOOR_CYCLES cycles, then -> IDLE; exit re-evaluates direction per REQ-017.
REQ-022 door_open_btn or weight_sensor high SHALL reload door counter (door held); door_close_btn with weight_sensor low SHALL expire counter so exit occurs next edge.
REQ-023 Simultaneous set and clear of the same request bit: clear wins.
REQ-024 power_switch low from any state SHALL -> OFF next edge: all outputs except current_floor 0, requests cleared, buttons ignored; power restore -> IDLE, floor retained, mid-floor travel discarded.
REQ-025 emergency_btn high (power on) SHALL -> EMERGENCY from any state; behaviour per REQ-030/031; exit to IDLE when emergency_btn low.
REQ-026 Priority per cycle: power off > emergency > door controls > requests.

Reset
REQ-027 reset high SHALL force, asynchronously: state IDLE, current_floor 0, direction_up 1, moving 0, door_open 0, all requests/lights 0, counters 0.
REQ-028 Reset mid-travel SHALL abandon the move; no floor step after reset release until a new request.

Configuration
REQ-029 Macro ELEVATOR_EMERGENCY_RECALL_EN selects emergency behaviour.
REQ-030 Defined: EMERGENCY clears requests, travels down at TRAVEL_CYCLES per floor to floor 0, then door_open=1 until emergency_btn low.
REQ-031 Undefined: EMERGENCY freezes position and counters, moving=0, door_open=0, requests retained and still latched.

Structure
REQ-032 Shared package elevator_pkg SHALL hold state encoding constants and default parameter values.
REQ-033 Sub-module elevator_request_bank SHALL hold request bits, set/clear logic, and any_above/any_below/at_floor flags versus current_floor.

Verification
REQ-034 Defaults; reset, pulse panel_buttons[5] one cycle -> panel_lights[5]=1 next cycle, floor reaches 5 after 20 cycles in MOVING, door_open=1 for 8 cycles, light cleared.
REQ-035 At floor 5 moving up to 9, press call_buttons[2] and [7] -> stops at 7 then 9, reverses, stops at 2.
REQ-036 In DOOR_OPEN hold weight_sensor=1 for 20 cycles -> door_open stays 1; release and pulse door_close_btn -> IDLE next edge.
REQ-037 Power off mid-travel between floors 3 and 4 -> OFF, lights 0, floor stays 3; power on -> IDLE, no motion.
REQ-038 Emergency at floor 6 with requests 8,9 -> with macro: lights 0, reaches floor 0 in 24 cycles, door opens; without: frozen at 6, lights 8,9 retained, resumes after release.
REQ-039 Assert reset during MOVING -> outputs at REQ-027 values immediately, independent of clock.
